// File: rtl/lcd_scandoubler.sv
// lcd_scandoubler: replays each half-rate LCD line twice at full clock rate
// and maps the 2-bit shades to RGB444 through a grey or green palette.
module lcd_scandoubler #(
    parameter int ADDR_W   = 8,
    parameter int LINE_DEF = 456,
    parameter int HS_START = 184,
    parameter int HS_W     = 20,
    parameter int LEN_MIN  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_in,
    input  logic [1:0] pix_in,
    input  logic       active_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       tint,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       hs_out,
    output logic       vs_out,
    output logic       active_out
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int AW1   = ADDR_W + 1;

    localparam logic [9:0]        CNT_MAX  = 10'd1023;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [9:0]        HS_LO    = 10'(HS_START);
    localparam logic [9:0]        HS_HI    = 10'(HS_START + HS_W);

    // input side state
    logic              r_hs_q1;
    logic              r_hs_q2;
    logic [9:0]        r_in_cnt;
    logic [9:0]        r_line_len;
    logic              r_wbank;
    logic [ADDR_W-1:0] r_wptr;
    logic [AW1-1:0]    r_act_cur;
    logic [AW1-1:0]    r_act_prev;

    // output side state
    logic [9:0]        r_out_h;
    logic              r_pass;
    logic [1:0]        r_mem [0:2*DEPTH-1];
    logic [1:0]        r_rd;
    logic              r_vis1;
    logic              r_hsn1;
    logic              r_vs1;

    logic              w_hs_fall;
    logic              w_wr_en;
    logic              w_ptr_adv;
    logic [10:0]       w_meas;
    logic              w_len_ok;
    logic [AW1-1:0]    w_act_next;
    logic [9:0]        w_half;
    logic              w_wrap;
    logic              w_vis;
    logic              w_hs_win;

    assign w_hs_fall  = r_hs_q2 & ~r_hs_q1;
    assign w_wr_en    = ce_in & active_in;
    assign w_ptr_adv  = w_wr_en && (r_wptr != PTR_LAST);
    assign w_meas     = {1'b0, r_in_cnt} + 11'd1;
    assign w_len_ok   = (w_meas >= 11'(LEN_MIN)) && (w_meas <= 11'd1023);
    assign w_act_next = w_ptr_adv ? r_act_cur + AW1'(1) : r_act_cur;
    assign w_half     = r_line_len >> 1;
    assign w_wrap     = ~r_pass && (r_out_h == w_half - 10'd1);
    assign w_vis      = r_out_h < 10'(r_act_prev);
    assign w_hs_win   = (r_out_h >= HS_LO) && (r_out_h < HS_HI);

    function automatic logic [11:0] f_pal(input logic [1:0] s,
                                          input logic t);
        logic [11:0] c;
        c = 12'h000;
        case ({t, s})
            3'b000:  c = 12'hFFF;
            3'b001:  c = 12'hAAA;
            3'b010:  c = 12'h555;
            3'b011:  c = 12'h000;
            3'b100:  c = 12'hAC2;
            3'b101:  c = 12'h692;
            3'b110:  c = 12'h363;
            default: c = 12'h131;
        endcase
        return c;
    endfunction

    // line measurement and write-side bank/pointer control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_q1    <= 1'b1;
            r_hs_q2    <= 1'b1;
            r_in_cnt   <= '0;
            r_line_len <= 10'(LINE_DEF);
            r_wbank    <= 1'b0;
            r_wptr     <= '0;
            r_act_cur  <= '0;
            r_act_prev <= '0;
        end else begin
            r_hs_q1 <= hs_in;
            r_hs_q2 <= r_hs_q1;
            if (w_hs_fall) begin
                r_in_cnt   <= '0;
                r_act_prev <= w_act_next;
                r_act_cur  <= '0;
                r_wptr     <= '0;
                r_wbank    <= ~r_wbank;
                if (w_len_ok) begin
                    r_line_len <= w_meas[9:0];
                end
            end else begin
                if (r_in_cnt != CNT_MAX) begin
                    r_in_cnt <= r_in_cnt + 10'd1;
                end
                if (w_ptr_adv) begin
                    r_wptr <= r_wptr + ADDR_W'(1);
                end
                r_act_cur <= w_act_next;
            end
        end
    end

    // line buffer: write bank wbank, read the other bank
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wbank, r_wptr}] <= pix_in;
        end
        r_rd <= r_mem[{~r_wbank, r_out_h[ADDR_W-1:0]}];
    end

    // output h-counter and two-stage output pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_h    <= '0;
            r_pass     <= 1'b0;
            r_vis1     <= 1'b0;
            r_hsn1     <= 1'b1;
            r_vs1      <= 1'b0;
            r          <= '0;
            g          <= '0;
            b          <= '0;
            hs_out     <= 1'b1;
            vs_out     <= 1'b0;
            active_out <= 1'b0;
        end else begin
            if (w_hs_fall) begin
                r_out_h <= '0;
                r_pass  <= 1'b0;
            end else if (w_wrap) begin
                r_out_h <= '0;
                r_pass  <= 1'b1;
            end else if (r_out_h != CNT_MAX) begin
                r_out_h <= r_out_h + 10'd1;
            end

            r_vis1 <= w_vis;
            r_hsn1 <= ~w_hs_win;
            r_vs1  <= vs_in;

            if (r_vis1) begin
                {r, g, b} <= f_pal(r_rd, tint);
            end else begin
                {r, g, b} <= 12'h000;
            end
            hs_out     <= r_hsn1;
            vs_out     <= r_vs1;
            active_out <= r_vis1;
        end
    end

endmodule
